// File: rtl/multicycle_control_pkg.sv
// Shared opcode, state and datapath-select encodings for the multicycle controller,
// the ALU control block and the datapath.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RCOMP   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_ADDI   = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// Moore main controller for the multicycle MIPS-subset CPU; outputs decode State directly
// (zero latency), 3-5 cycles per instruction, no backpressure.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] State
);

  state_t state, next_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  assign State = state;

  always_comb begin
    next_state  = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;

    case (state)
      S_FETCH: begin
        MemRead    = 1'b1;
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (Op)
          OP_LW, OP_SW: next_state = S_MEMADDR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_FUNCT;
        next_state = S_RCOMP;
      end
      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_ADDI;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset parks the FSM in FETCH; suppress its strobes so nothing is written while held.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle output vectors predicted from the
// state table are queued per instruction and compared at each falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];
  logic [19:0] got, exp_v;

  multicycle_control dut (
    .clk(clk), .rst(rst), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .State(State)
  );

  always #5 clk = ~clk;

  wire [19:0] dut_vec = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                         IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

  // Expected outputs straight from the state table, with strobes cleared while in reset.
  function automatic logic [19:0] model(input int s, input logic r);
    logic pcw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, m2r = 0, irw = 0;
    logic srca = 0, rw = 0, rd = 0;
    logic [1:0] pcsrc = 2'b00, aluop = 2'b00, srcb = 2'b00;
    case (s)
      0:  begin pcw = 1; mr = 1; irw = 1; srcb = 2'b01; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin srca = 1; aluop = 2'b01; pwc = 1; pcsrc = 2'b01; end
      9:  begin pcw = 1; pcsrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
      11: rw = 1;
      default: ;
    endcase
    if (r) begin pcw = 0; pwc = 0; mr = 0; mw = 0; irw = 0; rw = 0; end
    return {s[3:0], pcw, pwc, iord, mr, mw, m2r, irw, pcsrc, aluop, srca, srcb, rw, rd};
  endfunction

  task automatic push_seq(input int n, input int s0, input int s1, input int s2,
                          input int s3, input int s4);
    int seq[5];
    seq = '{s0, s1, s2, s3, s4};
    for (int i = 0; i < n; i++) exp_q.push_back(model(seq[i], 1'b0));
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Op  = 6'b111111;
    #1;
    checks++;
    if (dut_vec !== model(0, 1'b1)) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", dut_vec, model(0, 1'b1));
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== model(0, 1'b1)) begin
      failures++;
      $display("FAIL reset_hold_edge got=%h exp=%h", dut_vec, model(0, 1'b1));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_instr(input string name, input logic [5:0] op, input int n,
                            input int s0, input int s1, input int s2, input int s3,
                            input int s4);
    Op = op;
    push_seq(n, s0, s1, s2, s3, s4);
    for (int i = 0; i < n; i++) begin
      got = dut_vec;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s cyc%0d scoreboard empty got=%h", name, i, got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got, exp_v);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_op_toggle();
    Op = 6'b100011;
    push_seq(5, 0, 1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      got = dut_vec;
      checks++;
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        failures++;
        $display("FAIL lw_op_toggle cyc%0d got=%h exp=%h", i, got, exp_v);
      end
      // Scribble Op while in MEMRD/MEMWB; the lw flow must not notice.
      if (i == 3) Op = 6'b000100;
      if (i == 4) Op = 6'b101011;
      next_cycle();
    end
  endtask

  task automatic test_async_abort();
    Op = 6'b101011;
    push_seq(4, 0, 1, 2, 5, 0);
    for (int i = 0; i < 4; i++) begin
      got = dut_vec;
      checks++;
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        failures++;
        $display("FAIL abort_sw cyc%0d got=%h exp=%h", i, got, exp_v);
      end
      if (i < 3) next_cycle();
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== model(0, 1'b1)) begin
      failures++;
      $display("FAIL abort_async got=%h exp=%h", dut_vec, model(0, 1'b1));
    end
    checks++;
    if (MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL abort_memwrite got=%b exp=0", MemWrite);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    test_instr("b2b_rtype", 6'b000000, 4, 0, 6, 7, 0, 0);
  endtask

  initial begin
    test_reset();
    test_instr("lw",      6'b100011, 5, 0, 1, 2, 3, 4);
    test_instr("sw",      6'b101011, 4, 0, 1, 2, 5, 0);
    test_instr("rtype",   6'b000000, 4, 0, 1, 6, 7, 0);
    test_instr("beq",     6'b000100, 3, 0, 1, 8, 0, 0);
    test_instr("jump",    6'b000010, 3, 0, 1, 9, 0, 0);
    test_instr("addi",    6'b001000, 4, 0, 1, 10, 11, 0);
    test_instr("illegal", 6'b111111, 2, 0, 1, 0, 0, 0);
    test_instr("illegal2",6'b010101, 2, 0, 1, 0, 0, 0);
    test_op_toggle();
    test_async_abort();
    test_instr("post_abort_j", 6'b000010, 3, 0, 1, 9, 0, 0);
    test_instr("lw_again",     6'b100011, 5, 0, 1, 2, 3, 4);
    checks++;
    if (dut_vec !== model(0, 1'b0)) begin
      failures++;
      $display("FAIL final_fetch got=%h exp=%h", dut_vec, model(0, 1'b0));
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=stalled exp=finish");
    $fatal(1, "timeout");
  end

endmodule
